// File: rtl/jt1943_dwnld_pkg.sv
// Shared types and constants for the ioctl ROM downloader.
package jt1943_dwnld_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } st_e;

  localparam logic [1:0] MASK_LO   = 2'b10;
  localparam logic [1:0] MASK_HI   = 2'b01;
  localparam logic [1:0] MASK_NONE = 2'b11;

  localparam logic [21:0] DEF_PROM_START = 22'h48000;
  localparam int          DEF_PROM_CNT   = 8;
  localparam logic [7:0]  DEF_TIMEOUT    = 8'd255;

  typedef struct packed {
    logic [21:0] addr;
    logic [7:0]  data;
  } wr_t;

  function automatic logic [1:0] byte_mask(input logic odd);
    return odd ? MASK_HI : MASK_LO;
  endfunction

endpackage

// File: rtl/jt1943_dwnld_if.sv
// ioctl byte stream in, SDRAM programming port out.
interface jt1943_dwnld_if;
  logic [21:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wr;
  logic [21:0] prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask;
  logic        prog_we;
  logic        prog_rdy;

  modport master (
    input  ioctl_addr, ioctl_data, ioctl_wr, prog_rdy,
    output prog_addr, prog_data, prog_mask, prog_we
  );

  modport slave (
    output ioctl_addr, ioctl_data, ioctl_wr, prog_rdy,
    input  prog_addr, prog_data, prog_mask, prog_we
  );
endinterface

// File: rtl/jt1943_dwnld_skid.sv
// One-entry skid buffer; full_o already accounts for a same-cycle pop.
module jt1943_dwnld_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         valid_o,
  output logic         full_o
);
  logic         valid_q;
  logic [W-1:0] data_q;

  assign valid_o = valid_q;
  assign dout_o  = data_q;
  assign full_o  = valid_q & ~pop_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (push_i && !full_o) begin
      valid_q <= 1'b1;
      data_q  <= din_i;
    end else if (pop_i) begin
      valid_q <= 1'b0;
    end
  end
endmodule

// File: rtl/jt1943_dwnld.sv
// ROM download router: SDRAM byte writes with ready handshake, PROM region
// diverted to one-hot write pulses, done pulse and sticky error.
module jt1943_dwnld
  import jt1943_dwnld_pkg::*;
#(
  parameter logic [21:0] PROM_START = DEF_PROM_START,
  parameter int          PROM_CNT   = DEF_PROM_CNT,
  parameter logic [7:0]  TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                downloading,
  jt1943_dwnld_if.master      bus,
  output logic [PROM_CNT-1:0] prom_we,
  output logic [7:0]          prom_addr,
  output logic [3:0]          prom_din,
  output logic                dwn_done,
  output logic                err
);
  localparam logic [22:0] PROM_END = {1'b0, PROM_START} + 23'(256 * PROM_CNT);

  st_e                st_q;
  logic [7:0]         cnt_q;
  logic               prog_we_q;
  logic [21:0]        prog_addr_q;
  logic [7:0]         prog_data_q;
  logic [1:0]         prog_mask_q;
  logic [PROM_CNT-1:0] prom_we_q;
  logic [7:0]         prom_addr_q;
  logic [3:0]         prom_din_q;
  logic               done_q, err_q, pend_q, dl_q;

  wr_t  new_wr, skid_dout, iss;
  logic wr_ok, in_sd, in_pr, is_sd, is_pr, idle;
  logic dl_rise, dl_fall, pop, issue, push, ovf, tmo;
  logic skid_vld, skid_full;
  logic [2:0]          prom_idx;
  logic [PROM_CNT-1:0] prom_we_d;

  assign new_wr   = '{addr: bus.ioctl_addr, data: bus.ioctl_data};
  assign wr_ok    = bus.ioctl_wr & downloading;
  assign in_sd    = bus.ioctl_addr < PROM_START;
  assign in_pr    = !in_sd && ({1'b0, bus.ioctl_addr} < PROM_END);
  assign is_sd    = wr_ok & in_sd;
  assign is_pr    = wr_ok & in_pr;
  assign dl_rise  = downloading & ~dl_q;
  assign dl_fall  = ~downloading & dl_q;
  assign idle     = (st_q == ST_IDLE);

  // A parked byte always goes out before a fresh one; the fresh one then
  // takes the slot the parked byte just vacated.
  assign pop      = idle & skid_vld;
  assign issue    = idle & (skid_vld | is_sd);
  assign push     = is_sd & ~(idle & ~skid_vld);
  assign ovf      = push & skid_full;
  assign tmo      = ~idle & ~bus.prog_rdy & (cnt_q == TIMEOUT);
  assign iss      = skid_vld ? skid_dout : new_wr;

  assign prom_idx  = 3'((bus.ioctl_addr - PROM_START) >> 8);
  assign prom_we_d = is_pr ? (PROM_CNT'(1) << prom_idx) : '0;

  jt1943_dwnld_skid #(.W($bits(wr_t))) u_skid (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (new_wr),
    .dout_o  (skid_dout),
    .valid_o (skid_vld),
    .full_o  (skid_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= ST_IDLE;
      cnt_q       <= 8'd0;
      prog_we_q   <= 1'b0;
      prog_addr_q <= 22'd0;
      prog_data_q <= 8'd0;
      prog_mask_q <= MASK_NONE;
      prom_we_q   <= '0;
      prom_addr_q <= 8'd0;
      prom_din_q  <= 4'd0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      pend_q      <= 1'b0;
      dl_q        <= 1'b0;
    end else begin
      dl_q      <= downloading;
      done_q    <= 1'b0;
      prom_we_q <= prom_we_d;
      if (is_pr) begin
        prom_addr_q <= bus.ioctl_addr[7:0];
        prom_din_q  <= bus.ioctl_data[3:0];
      end

      case (st_q)
        ST_IDLE: if (issue) begin
          st_q        <= ST_WAIT;
          prog_we_q   <= 1'b1;
          cnt_q       <= 8'd0;
          prog_addr_q <= {1'b0, iss.addr[21:1]};
          prog_data_q <= iss.data;
          prog_mask_q <= byte_mask(iss.addr[0]);
        end
        ST_WAIT: if (bus.prog_rdy || tmo) begin
          st_q        <= ST_IDLE;
          prog_we_q   <= 1'b0;
          prog_mask_q <= MASK_NONE;
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
      endcase

      if (dl_rise)    err_q <= 1'b0;
      if (ovf || tmo) err_q <= 1'b1;

      // Completion waits for the last in-flight and parked writes to retire.
      if (dl_fall) begin
        pend_q <= 1'b1;
      end else if (dl_rise) begin
        pend_q <= 1'b0;
      end else if (pend_q && idle && !skid_vld) begin
        done_q <= 1'b1;
        pend_q <= 1'b0;
      end
    end
  end

  assign bus.prog_we   = prog_we_q;
  assign bus.prog_addr = prog_addr_q;
  assign bus.prog_data = prog_data_q;
  assign bus.prog_mask = prog_mask_q;
  assign prom_we       = prom_we_q;
  assign prom_addr     = prom_addr_q;
  assign prom_din      = prom_din_q;
  assign dwn_done      = done_q;
  assign err           = err_q;
endmodule

// File: tb/tb_jt1943_dwnld.sv
// Directed bench for jt1943_dwnld with default parameters.
module tb_jt1943_dwnld;
  logic       clk = 1'b0;
  logic       rst;
  logic       downloading;
  logic [7:0] prom_we;
  logic [7:0] prom_addr;
  logic [3:0] prom_din;
  logic       dwn_done;
  logic       err;
  int total = 0;
  int bad = 0;

  jt1943_dwnld_if bus();

  jt1943_dwnld dut (
    .clk         (clk),
    .rst         (rst),
    .downloading (downloading),
    .bus         (bus),
    .prom_we     (prom_we),
    .prom_addr   (prom_addr),
    .prom_din    (prom_din),
    .dwn_done    (dwn_done),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [21:0] a, input logic [7:0] d);
    bus.ioctl_addr = a;
    bus.ioctl_data = d;
    bus.ioctl_wr   = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    total++; if (bus.prog_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%0h exp=0", bus.prog_we); end
    total++; if (bus.prog_mask !== 2'b11) begin bad++; $display("FAIL rst_mask got=%0h exp=3", bus.prog_mask); end
    total++; if (prom_we !== 8'h00) begin bad++; $display("FAIL rst_prom_we got=%0h exp=0", prom_we); end
    rst = 1'b0;
    downloading = 1'b1;
    tick();
    put(22'h10, 8'h01);
    tick();
    bus.ioctl_wr = 1'b0;
    total++; if (bus.prog_we !== 1'b1) begin bad++; $display("FAIL rst_pre_we got=%0h exp=1", bus.prog_we); end
    tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    total++; if (bus.prog_we !== 1'b0) begin bad++; $display("FAIL rst_mid_we got=%0h exp=0", bus.prog_we); end
    total++; if (bus.prog_mask !== 2'b11) begin bad++; $display("FAIL rst_mid_mask got=%0h exp=3", bus.prog_mask); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_mid_err got=%0h exp=0", err); end
    for (int i = 0; i < 4; i++) begin
      total++; if ((dwn_done | bus.prog_we) !== 1'b0) begin bad++; $display("FAIL rst_after cyc=%0d done=%0h we=%0h exp=0", i, dwn_done, bus.prog_we); end
      tick();
    end
  endtask

  task automatic test_basic();
    put(22'h00101, 8'hA5);
    tick();
    bus.ioctl_wr = 1'b0;
    total++; if (bus.prog_addr !== 22'h00080) begin bad++; $display("FAIL basic_addr got=%0h exp=80", bus.prog_addr); end
    total++; if (bus.prog_mask !== 2'b01) begin bad++; $display("FAIL basic_mask got=%0h exp=1", bus.prog_mask); end
    total++; if (bus.prog_data !== 8'hA5) begin bad++; $display("FAIL basic_data got=%0h exp=a5", bus.prog_data); end
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.prog_we !== 1'b1) begin bad++; $display("FAIL basic_we cyc=%0d got=%0h exp=1", i, bus.prog_we); end
      if (i == 3) bus.prog_rdy = 1'b1;
      if (i < 3) tick();
    end
    tick();
    bus.prog_rdy = 1'b0;
    total++; if (bus.prog_we !== 1'b0) begin bad++; $display("FAIL basic_drop got=%0h exp=0", bus.prog_we); end
    tick();
  endtask

  task automatic test_back_to_back();
    put(22'h0, 8'h11);
    tick();
    put(22'h1, 8'h22);
    total++; if (bus.prog_mask !== 2'b10 || bus.prog_data !== 8'h11) begin bad++; $display("FAIL b2b_first mask=%0h data=%0h exp=2/11", bus.prog_mask, bus.prog_data); end
    tick();
    bus.ioctl_wr = 1'b0;
    tick();
    bus.prog_rdy = 1'b1;
    tick();
    bus.prog_rdy = 1'b0;
    total++; if (bus.prog_we !== 1'b0) begin bad++; $display("FAIL b2b_gap got=%0h exp=0", bus.prog_we); end
    tick();
    total++; if (bus.prog_we !== 1'b1 || bus.prog_mask !== 2'b01 || bus.prog_data !== 8'h22 || bus.prog_addr !== 22'h0) begin
      bad++; $display("FAIL b2b_second we=%0h mask=%0h data=%0h addr=%0h exp=1/1/22/0", bus.prog_we, bus.prog_mask, bus.prog_data, bus.prog_addr);
    end
    tick();
    tick();
    bus.prog_rdy = 1'b1;
    tick();
    bus.prog_rdy = 1'b0;
    total++; if (bus.prog_we !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL b2b_end we=%0h err=%0h exp=0/0", bus.prog_we, err); end
    tick();
  endtask

  task automatic test_overflow();
    put(22'h0, 8'h01);
    tick();
    put(22'h1, 8'h02);
    tick();
    put(22'h2, 8'h03);
    tick();
    bus.ioctl_wr = 1'b0;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL ovf_err got=%0h exp=1", err); end
    repeat (12) begin
      if (bus.prog_we) bus.prog_rdy = 1'b1;
      tick();
      bus.prog_rdy = 1'b0;
    end
    total++; if (bus.prog_we !== 1'b0 || err !== 1'b1) begin bad++; $display("FAIL ovf_sticky we=%0h err=%0h exp=0/1", bus.prog_we, err); end
  endtask

  task automatic test_prom();
    downloading = 1'b0;
    tick();
    downloading = 1'b1;
    tick();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clear got=%0h exp=0", err); end
    for (int i = 0; i < 3; i++) begin
      total++; if (dwn_done !== 1'b0) begin bad++; $display("FAIL done_cancel cyc=%0d got=%0h exp=0", i, dwn_done); end
      tick();
    end
    put(22'h48000 + 22'h2A3, 8'h7C);
    tick();
    bus.ioctl_wr = 1'b0;
    total++; if (prom_we !== 8'b0000_0100) begin bad++; $display("FAIL prom_we got=%0h exp=4", prom_we); end
    total++; if (prom_addr !== 8'hA3 || prom_din !== 4'hC) begin bad++; $display("FAIL prom_ad addr=%0h din=%0h exp=a3/c", prom_addr, prom_din); end
    total++; if (bus.prog_we !== 1'b0) begin bad++; $display("FAIL prom_prog_we got=%0h exp=0", bus.prog_we); end
    tick();
    total++; if (prom_we !== 8'h00) begin bad++; $display("FAIL prom_pulse got=%0h exp=0", prom_we); end
  endtask

  task automatic test_timeout();
    int n;
    put(22'h10, 8'h5A);
    tick();
    bus.ioctl_wr = 1'b0;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL tmo_pre_err got=%0h exp=0", err); end
    n = 0;
    for (int i = 0; i < 300 && bus.prog_we; i++) begin
      n++;
      tick();
    end
    total++; if (n !== 256) begin bad++; $display("FAIL tmo_len got=%0d exp=256", n); end
    total++; if (err !== 1'b1 || bus.prog_we !== 1'b0) begin bad++; $display("FAIL tmo_err err=%0h we=%0h exp=1/0", err, bus.prog_we); end
    tick();
  endtask

  task automatic test_done();
    int pulses;
    put(22'h4, 8'h33);
    tick();
    bus.ioctl_wr = 1'b0;
    downloading = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (dwn_done !== 1'b0 || bus.prog_we !== 1'b1) begin bad++; $display("FAIL done_early cyc=%0d done=%0h we=%0h exp=0/1", i, dwn_done, bus.prog_we); end
    end
    bus.prog_rdy = 1'b1;
    tick();
    bus.prog_rdy = 1'b0;
    total++; if (dwn_done !== 1'b0 || bus.prog_we !== 1'b0) begin bad++; $display("FAIL done_idle done=%0h we=%0h exp=0/0", dwn_done, bus.prog_we); end
    tick();
    total++; if (dwn_done !== 1'b1) begin bad++; $display("FAIL done_pulse got=%0h exp=1", dwn_done); end
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (dwn_done) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL done_single extra=%0d exp=0", pulses); end
    downloading = 1'b1;
    tick();
    put(22'h3FFFFF, 8'hFF);
    tick();
    bus.ioctl_wr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++; if (bus.prog_we !== 1'b0 || prom_we !== 8'h00 || bus.prog_mask !== 2'b11) begin
        bad++; $display("FAIL discard cyc=%0d we=%0h prom_we=%0h mask=%0h exp=0/0/3", i, bus.prog_we, prom_we, bus.prog_mask);
      end
      tick();
    end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL discard_err got=%0h exp=0", err); end
  endtask

  initial begin
    rst = 1'b1;
    downloading = 1'b0;
    bus.ioctl_addr = '0;
    bus.ioctl_data = '0;
    bus.ioctl_wr = 1'b0;
    bus.prog_rdy = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_prom();
    test_timeout();
    test_done();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/jt1943_dwnld.md
Name: jt1943_dwnld

Overview:
- Sits between the frame's ioctl download port and the SDRAM programming port / on-chip PROMs during ROM load.
- Turns the byte stream (ioctl_addr/ioctl_data/ioctl_wr) into SDRAM byte-masked word writes (prog_*) with a ready handshake.
- Diverts the colour/priority PROM region into one-hot on-chip PROM write pulses.
- Signals completion and sticky overrun/timeout errors.

Parameters:
- PROM_START, 22'h48000, first ioctl byte address of the PROM region.
- PROM_CNT, 8, number of 256-byte PROMs in the region (1..8).
- TIMEOUT, 8'd255, cycles to wait for prog_rdy before dropping a write.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- downloading  in  1  download window active
- ioctl_addr  in  22  byte address from the io controller
- ioctl_data  in  8  byte data
- ioctl_wr  in  1  one-cycle byte strobe
- prog_addr  out  22  SDRAM word address (ioctl_addr>>1)
- prog_data  out  8  byte to write (SDRAM side duplicates it onto both lanes)
- prog_mask  out  2  active-low byte enable: 2'b10 = low byte, 2'b01 = high byte
- prog_we  out  1  write request, held until accepted
- prog_rdy  in  1  SDRAM accept, one-cycle pulse
- prom_we  out  PROM_CNT  one-hot PROM write pulse
- prom_addr  out  8  PROM byte address
- prom_din  out  4  PROM nibble (ioctl_data[3:0])
- dwn_done  out  1  one-cycle pulse when the download has finished and all writes are retired
- err  out  1  sticky overrun/timeout flag; cleared on rst or on the rising edge of downloading

Behaviour:
- Reset values: all outputs 0, except prog_mask = 2'b11. FSM goes to IDLE, timeout counter to 0. rst mid-write abandons the write with no completion pulse.
- ioctl_wr is ignored while downloading = 0.
- Address classes:
  - SDRAM: ioctl_addr < PROM_START.
  - PROM: PROM_START <= ioctl_addr < PROM_START + 256*PROM_CNT.
  - Any other address: byte discarded silently.
- Latency: ioctl_wr at cycle n gives prog_we (SDRAM class) or prom_we (PROM class) at cycle n+1.
- PROM path:
  - prom_we[(ioctl_addr-PROM_START)>>8] pulses for exactly one cycle.
  - prom_addr = ioctl_addr[7:0], prom_din = ioctl_data[3:0].
  - Does not use the SDRAM FSM, so a PROM byte can arrive while the FSM is in WAIT.
- SDRAM FSM, states IDLE, WAIT:
  - IDLE: on an SDRAM-class ioctl_wr, register prog_addr, prog_data, prog_mask (mask = ioctl_addr[0] ? 2'b01 : 2'b10). Assert prog_we, clear the counter, go to WAIT.
  - WAIT: prog_we and the registered address/data/mask stay stable.
    - If prog_rdy: deassert prog_we next cycle and go to IDLE.
    - Else if counter == TIMEOUT: deassert prog_we, set err, go to IDLE.
    - Else: counter + 1.
  - WAIT is always left via IDLE, so prog_we drops for at least one cycle between writes.
- Buffer: one-entry skid register.
  - An SDRAM-class byte arriving in WAIT is stored and issued in the cycle after WAIT exits.
  - A byte arriving while the skid is already full sets err and is dropped.
  - If prog_rdy and a new byte coincide in WAIT, the new byte goes to the skid.
- prog_rdy seen in IDLE is ignored.
- dwn_done:
  - Triggered by the falling edge of downloading, then asserted once the FSM is in IDLE with the skid empty.
  - Exactly one pulse per download window. A new rising edge of downloading before the pulse cancels it.
- A byte accepted with downloading = 1 completes even if downloading falls while it is in flight.
- Counter width is 8 bits; it never wraps because the TIMEOUT compare exits first.

Decomposition:
- Shared package jt1943_dwnld_pkg:
  - state encoding (IDLE, WAIT);
  - mask constants MASK_LO = 2'b10, MASK_HI = 2'b01, MASK_NONE = 2'b11;
  - default region constants.
- One natural sub-module: jt1943_dwnld_skid, the one-entry buffer with valid/full flags, reusable by other core downloaders.

Test Plan:
- Reset: drive rst for 2 cycles mid-WAIT -> next cycle prog_we = 0, prog_mask = 2'b11, err = 0, no dwn_done.
- Basic write:
  - Stimulus: downloading = 1, ioctl_wr with addr 22'h00101, data 8'hA5; prog_rdy after 3 cycles.
  - Response: prog_we high from n+1 for 4 cycles, prog_addr = 22'h00080, prog_mask = 2'b01, prog_data = 8'hA5.
- Back-to-back:
  - Stimulus: two bytes 1 cycle apart (addr 0 then 1), prog_rdy 2 cycles after each prog_we.
  - Response: second write issued from the skid with mask 2'b01; err stays 0. A third byte during the first WAIT sets err = 1.
- PROM:
  - Stimulus: write addr PROM_START + 22'h2A3, data 8'h7C.
  - Response: prom_we = 8'b0000_0100 for one cycle, prom_addr = 8'hA3, prom_din = 4'hC, prog_we stays 0.
- Timeout: SDRAM write with prog_rdy never asserted -> prog_we drops after TIMEOUT+1 WAIT cycles (256 with the default TIMEOUT, including the cycle with counter = TIMEOUT), err = 1.
- Done:
  - Stimulus: drop downloading while a write is in WAIT, prog_rdy 5 cycles later.
  - Response: a single dwn_done pulse 1 cycle after the FSM returns to IDLE. A byte to addr 22'h3FFFFF is discarded with no outputs.
